// File: rtl/obstacle_field_if.sv
// Game-tick bundle between the tick generator/crash checker and obstacle_field.
// The game side drives step/game_over as master; the obstacle scroller is the slave.
interface obstacle_field_if #(
   parameter int N_OBS   = 4,
   parameter int X_W     = 10,
   parameter int SCORE_W = 8
) ();
   logic                   step;
   logic                   game_over;
   logic [N_OBS*X_W-1:0]   obs_x;
   logic [N_OBS*X_W-1:0]   obs_y;
   logic [SCORE_W-1:0]     score;
   logic [2:0]             speed;

   modport master (
      output step, game_over,
      input  obs_x, obs_y, score, speed
   );

   modport slave (
      input  step, game_over,
      output obs_x, obs_y, score, speed
   );
endinterface

// File: rtl/obstacle_field.sv
// N-channel obstacle scroller: scrolls, respawns with LFSR heights and scores plane crossings.
// Optional speed ramp with score is enabled by defining OBSTACLE_FIELD_SPEEDUP_EN.
module obstacle_field #(
   parameter int N_OBS         = 4,
   parameter int X_W           = 10,
   parameter int SPACING       = 160,
   parameter int PLANE_X       = 100,
   parameter int Y_MIN         = 100,
   parameter int Y_RANGE_LOG2  = 8,
   parameter int BASE_SPEED    = 2,
   parameter int MAX_SPEED     = 7,
   parameter int SPEEDUP_EVERY = 8,
   parameter int SCORE_W       = 8
) (
   input logic                clk,
   input logic                resetn,
   obstacle_field_if.slave    bus
);
   localparam int            XW1      = X_W + 1;
   localparam logic [X_W:0]  PERIOD_E = XW1'(N_OBS * SPACING);
   localparam logic [X_W:0]  PLANE_E  = XW1'(PLANE_X);
   localparam logic [X_W-1:0] Y_BASE  = X_W'(Y_MIN);
   localparam logic [SCORE_W-1:0] SMAX = {SCORE_W{1'b1}};

   logic [X_W-1:0]     x_q [N_OBS];
   logic [X_W-1:0]     x_d [N_OBS];
   logic [X_W-1:0]     y_q [N_OBS];
   logic [X_W-1:0]     y_d [N_OBS];
   logic [X_W:0]       x_old [N_OBS];
   logic [X_W:0]       x_new [N_OBS];
   logic               hit [N_OBS];
   logic [SCORE_W-1:0] score_q, score_d;
   logic [SCORE_W:0]   score_sum;
   logic [3:0]         pts;
   logic [15:0]        lfsr_q, lfsr_d;
   logic               lfsr_fb;
   logic               adv;
   logic [2:0]         speed_cur;
   logic [X_W:0]       spd_e;

   assign adv     = bus.step & ~bus.game_over;
   assign lfsr_fb = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
   assign lfsr_d  = adv ? {lfsr_q[14:0], lfsr_fb} : lfsr_q;
   assign spd_e   = XW1'(speed_cur);

   // x math is one bit wider so the respawn sum x + period cannot overflow before the subtract
   always_comb begin
      pts = 4'd0;
      for (int i = 0; i < N_OBS; i++) begin
         x_old[i] = {1'b0, x_q[i]};
         x_new[i] = x_old[i];
         hit[i]   = 1'b0;
         x_d[i]   = x_q[i];
         y_d[i]   = y_q[i];
         if (x_old[i] >= spd_e) begin
            x_new[i] = x_old[i] - spd_e;
            hit[i]   = adv && (x_old[i] >= PLANE_E) && (x_new[i] < PLANE_E);
         end else begin
            x_new[i] = x_old[i] + PERIOD_E - spd_e;
         end
         if (adv) begin
            x_d[i] = x_new[i][X_W-1:0];
            if (x_old[i] < spd_e)
               y_d[i] = Y_BASE + X_W'(lfsr_q[Y_RANGE_LOG2-1:0] ^ Y_RANGE_LOG2'(i));
         end
         pts = pts + 4'(hit[i]);
      end
   end

   always_comb begin
      score_sum = {1'b0, score_q} + (SCORE_W+1)'(pts);
      score_d   = score_q;
      if (adv)
         score_d = (score_sum > {1'b0, SMAX}) ? SMAX : score_sum[SCORE_W-1:0];
   end

`ifdef OBSTACLE_FIELD_SPEEDUP_EN
   logic [2:0] speed_q, speed_d;
   logic       bump_q, bump_d;

   // A crossing of a SPEEDUP_EVERY multiple is remembered and applied on the next advance
   always_comb begin
      speed_d = speed_q;
      bump_d  = bump_q;
      if (adv) begin
         if (bump_q && (speed_q < 3'(MAX_SPEED)))
            speed_d = speed_q + 3'd1;
         bump_d = (32'(score_d) / SPEEDUP_EVERY) > (32'(score_q) / SPEEDUP_EVERY);
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         speed_q <= 3'(BASE_SPEED);
         bump_q  <= 1'b0;
      end else begin
         speed_q <= speed_d;
         bump_q  <= bump_d;
      end
   end

   assign speed_cur = speed_q;
`else
   assign speed_cur = 3'(BASE_SPEED);
`endif

   always_ff @(posedge clk) begin
      if (!resetn) begin
         for (int i = 0; i < N_OBS; i++) begin
            x_q[i] <= X_W'((i + 1) * SPACING);
            y_q[i] <= Y_BASE;
         end
         score_q <= '0;
         lfsr_q  <= 16'hACE1;
      end else begin
         for (int i = 0; i < N_OBS; i++) begin
            x_q[i] <= x_d[i];
            y_q[i] <= y_d[i];
         end
         score_q <= score_d;
         lfsr_q  <= lfsr_d;
      end
   end

   for (genvar g = 0; g < N_OBS; g++) begin : g_pack
      assign bus.obs_x[g*X_W +: X_W] = x_q[g];
      assign bus.obs_y[g*X_W +: X_W] = y_q[g];
   end

   assign bus.score = score_q;
   assign bus.speed = speed_cur;
endmodule

// File: tb/tb_obstacle_field.sv
// Scoreboard bench for obstacle_field: driver pushes model/directed expectations, monitor compares.
module tb_obstacle_field;
   localparam int N  = 4;
   localparam int XW = 10;
`ifdef OBSTACLE_FIELD_SPEEDUP_EN
   localparam int SW = 4;
`else
   localparam int SW = 8;
`endif
   localparam int SMAXI = (1 << SW) - 1;

   logic clk    = 1'b0;
   logic resetn = 1'b0;
   always #5 clk = ~clk;

   obstacle_field_if #(.N_OBS(N), .X_W(XW), .SCORE_W(SW)) bus ();

   obstacle_field #(.N_OBS(N), .X_W(XW), .SCORE_W(SW)) dut (
      .clk    (clk),
      .resetn (resetn),
      .bus    (bus)
   );

   typedef struct {
      logic [N*XW-1:0] x;
      logic [N*XW-1:0] y;
      logic [SW-1:0]   sc;
      logic [2:0]      spd;
      int              tag;
      int              dx0, dx1, dx3, dsc, dspd;
   } exp_t;

   exp_t q[$];
   int   tests = 0;
   int   fails = 0;

   int          mx [N];
   int          my [N];
   int          msc, mspd;
   logic [15:0] mlfsr;
   bit          mbump;

   function automatic void model_reset();
      for (int i = 0; i < N; i++) begin
         mx[i] = (i + 1) * 160;
         my[i] = 100;
      end
      msc   = 0;
      mspd  = 2;
      mlfsr = 16'hACE1;
      mbump = 0;
   endfunction

   function automatic void model_adv();
      int pts;
      int nx;
      int old;
      pts = 0;
      for (int i = 0; i < N; i++) begin
         if (mx[i] >= mspd) begin
            nx = mx[i] - mspd;
            if (mx[i] >= 100 && nx < 100) pts++;
            mx[i] = nx;
         end else begin
            mx[i] = mx[i] + 640 - mspd;
            my[i] = 100 + ((int'(mlfsr) & 255) ^ i);
         end
      end
      old = msc;
      msc = (msc + pts > SMAXI) ? SMAXI : msc + pts;
`ifdef OBSTACLE_FIELD_SPEEDUP_EN
      if (mbump && mspd < 7) mspd++;
      mbump = (msc / 8) > (old / 8);
`endif
      mlfsr = {mlfsr[14:0], mlfsr[15] ^ mlfsr[13] ^ mlfsr[12] ^ mlfsr[10]};
   endfunction

   task automatic cyc(input bit rn, input bit st, input bit go,
                      input int tag = 0, input int dx0 = -1, input int dx1 = -1,
                      input int dx3 = -1, input int dsc = -1, input int dspd = -1);
      exp_t e;
      resetn        = rn;
      bus.step      = st;
      bus.game_over = go;
      @(posedge clk);
      #1;
      if (!rn) model_reset();
      else if (st && !go) model_adv();
      for (int i = 0; i < N; i++) begin
         e.x[i*XW +: XW] = XW'(mx[i]);
         e.y[i*XW +: XW] = XW'(my[i]);
      end
      e.sc   = SW'(msc);
      e.spd  = 3'(mspd);
      e.tag  = tag;
      e.dx0  = dx0;
      e.dx1  = dx1;
      e.dx3  = dx3;
      e.dsc  = dsc;
      e.dspd = dspd;
      q.push_back(e);
   endtask

   task automatic steps(input int n);
      repeat (n) cyc(1'b1, 1'b1, 1'b0);
   endtask

   function automatic void chk(input string nm, input int tag, input longint act, input longint exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s tag=%0d got %0d expected %0d at %0t", nm, tag, act, exp, $time);
      end
   endfunction

   always @(negedge clk) begin
      while (q.size() > 0) begin
         exp_t e;
         e = q.pop_front();
         for (int i = 0; i < N; i++) begin
            chk($sformatf("obs_x[%0d]", i), e.tag, longint'(bus.obs_x[i*XW +: XW]), longint'(e.x[i*XW +: XW]));
            chk($sformatf("obs_y[%0d]", i), e.tag, longint'(bus.obs_y[i*XW +: XW]), longint'(e.y[i*XW +: XW]));
         end
         chk("score", e.tag, longint'(bus.score), longint'(e.sc));
         chk("speed", e.tag, longint'(bus.speed), longint'(e.spd));
         if (e.dx0 >= 0)  chk("dir_x0", e.tag, longint'(bus.obs_x[0 +: XW]), e.dx0);
         if (e.dx1 >= 0)  chk("dir_x1", e.tag, longint'(bus.obs_x[XW +: XW]), e.dx1);
         if (e.dx3 >= 0)  chk("dir_x3", e.tag, longint'(bus.obs_x[3*XW +: XW]), e.dx3);
         if (e.dsc >= 0)  chk("dir_score", e.tag, longint'(bus.score), e.dsc);
         if (e.dspd >= 0) chk("dir_speed", e.tag, longint'(bus.speed), e.dspd);
      end
   end

   initial begin
      bus.step      = 1'b0;
      bus.game_over = 1'b0;
      model_reset();

      // reset, second reset edge with step/game_over active must still reset
      cyc(1'b0, 1'b0, 1'b0, 1, 160, 320, 640, 0, 2);
      cyc(1'b0, 1'b1, 1'b0, 1, 160, 320, 640, 0, 2);

      // scoring at the plane column
      steps(29);
      cyc(1'b1, 1'b1, 1'b0, 2, 100, 260, -1, 0, 2);
      cyc(1'b1, 1'b1, 1'b0, 3, 98, 258, -1, 1, 2);

      // wrap/respawn of channel 0
      steps(48);
      cyc(1'b1, 1'b1, 1'b0, 4, 0, 160, -1, 1, 2);
      cyc(1'b1, 1'b1, 1'b0, 5, 638, 158, -1, 1, 2);

      // freeze: step pulses under game_over change nothing
      repeat (10) begin
         cyc(1'b1, 1'b1, 1'b1, 6, 638, 158, -1, 1, 2);
         cyc(1'b1, 1'b0, 1'b1, 6, 638, 158, -1, 1, 2);
      end
      cyc(1'b1, 1'b0, 1'b0, 7, 638, 158, -1, 1, 2);
      cyc(1'b1, 1'b1, 1'b0, 8, 636, 156, -1, 1, 2);

      // mixed step / game_over pattern exercising respawns and frozen LFSR
      for (int i = 0; i < 600; i++)
         cyc(1'b1, (i % 3) != 2, (i % 50) == 7);

      // reset mid-game coinciding with step
      cyc(1'b0, 1'b0, 1'b0, 1, 160, 320, 640, 0, 2);
      steps(49);
      cyc(1'b1, 1'b1, 1'b0, 9, 60, 220, -1, 1, 2);
      cyc(1'b0, 1'b1, 1'b0, 10, 160, 320, 640, 0, 2);
      steps(5);

`ifdef OBSTACLE_FIELD_SPEEDUP_EN
      // speed ramps once at score 8, score saturates at 15
      cyc(1'b0, 1'b0, 1'b0, 1, 160, 320, 640, 0, 2);
      steps(3000);
      cyc(1'b1, 1'b1, 1'b0, 11, -1, -1, -1, 15, 3);
`endif

      repeat (3) @(posedge clk);
      if (q.size() != 0) begin
         tests++;
         fails++;
         $display("FAIL drain pending=%0d expected 0", q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
